// File: rtl/led_pattern_monitor_if.sv
// Interface bundling the LED bus, the sample/clear qualifiers and all monitor results.
// The master side drives the LED bus and controls; the slave side is the monitor.
interface led_pattern_monitor_if #(
  parameter int NB_LEDS = 4,
  parameter int NB_POS  = 2,
  parameter int NB_LAPS = 8
);
  logic [NB_LEDS-1:0] i_led;
  logic               i_sample;
  logic               i_clear;
  logic [NB_POS-1:0]  o_position;
  logic               o_dir;
  logic               o_step;
  logic               o_reversal;
  logic               o_locked;
  logic               o_error;
  logic [1:0]         o_err_code;
  logic [NB_LAPS-1:0] o_laps;

  modport master (
    output i_led, i_sample, i_clear,
    input  o_position, o_dir, o_step, o_reversal, o_locked, o_error, o_err_code, o_laps
  );

  modport slave (
    input  i_led, i_sample, i_clear,
    output o_position, o_dir, o_step, o_reversal, o_locked, o_error, o_err_code, o_laps
  );
endinterface

// File: rtl/led_pattern_monitor.sv
// Tracks a rotating one-hot LED pattern: locks onto the lit position, reports steps,
// direction reversals and wrap-around laps, and latches a sticky error on illegal patterns.
module led_pattern_monitor #(
  parameter int NB_LEDS = 4,
  parameter int NB_POS  = 2,
  parameter int NB_LAPS = 8
) (
  input  logic                 clock,
  input  logic                 i_reset,
  led_pattern_monitor_if.slave mon
);

  localparam logic [1:0] ST_SEEK  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_ONEHOT = 2'b01;
  localparam logic [1:0] ERR_JUMP   = 2'b10;

  localparam logic [NB_POS-1:0] LAST_POS = NB_POS'(NB_LEDS - 1);

  function automatic logic is_onehot(input logic [NB_LEDS-1:0] v);
    return (v != {NB_LEDS{1'b0}}) && ((v & (v - NB_LEDS'(1))) == {NB_LEDS{1'b0}});
  endfunction

  function automatic logic [NB_POS-1:0] lit_index(input logic [NB_LEDS-1:0] v);
    logic [NB_POS-1:0] idx;
    idx = {NB_POS{1'b0}};
    for (int i = 0; i < NB_LEDS; i++) begin
      if (v[i]) begin
        idx = NB_POS'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [1:0]         r_state;
  logic [NB_POS-1:0]  r_position;
  logic               r_dir;
  logic               r_step;
  logic               r_reversal;
  logic               r_locked;
  logic               r_error;
  logic [1:0]         r_err_code;
  logic [NB_LAPS-1:0] r_laps;
  logic               r_stepped;

  logic [1:0]         w_state;
  logic [NB_POS-1:0]  w_position;
  logic               w_dir;
  logic               w_step;
  logic               w_reversal;
  logic [1:0]         w_err_code;
  logic [NB_LAPS-1:0] w_laps;
  logic               w_stepped;

  logic               w_onehot;
  logic [NB_POS-1:0]  w_idx;
  logic [NB_POS-1:0]  w_fwd_idx;
  logic [NB_POS-1:0]  w_rev_idx;

  assign w_onehot  = is_onehot(mon.i_led);
  assign w_idx     = lit_index(mon.i_led);
  assign w_fwd_idx = (r_position == LAST_POS) ? {NB_POS{1'b0}} : r_position + NB_POS'(1);
  assign w_rev_idx = (r_position == {NB_POS{1'b0}}) ? LAST_POS : r_position - NB_POS'(1);

  // Next-state and next-output decode for the SEEK/TRACK/ERROR tracker
  always_comb begin
    w_state    = r_state;
    w_position = r_position;
    w_dir      = r_dir;
    w_step     = 1'b0;
    w_reversal = 1'b0;
    w_err_code = r_err_code;
    w_laps     = r_laps;
    w_stepped  = r_stepped;
    if (mon.i_clear) begin
      w_state    = ST_SEEK;
      w_position = {NB_POS{1'b0}};
      w_dir      = 1'b0;
      w_err_code = ERR_NONE;
      w_laps     = {NB_LAPS{1'b0}};
      w_stepped  = 1'b0;
    end else if (mon.i_sample) begin
      case (r_state)
        ST_SEEK: begin
          if (w_onehot) begin
            w_state    = ST_TRACK;
            w_position = w_idx;
            w_stepped  = 1'b0;
          end else begin
            w_state = ST_SEEK;
          end
        end
        ST_TRACK: begin
          // Not-one-hot is checked first so it wins over an illegal jump
          if (!w_onehot) begin
            w_state    = ST_ERROR;
            w_err_code = ERR_ONEHOT;
          end else if (w_idx == r_position) begin
            w_state = ST_TRACK;
          end else if (w_idx == w_fwd_idx) begin
            w_position = w_idx;
            w_dir      = 1'b0;
            w_step     = 1'b1;
            w_reversal = r_stepped && r_dir;
            w_stepped  = 1'b1;
            if (r_position == LAST_POS) begin
              w_laps = r_laps + NB_LAPS'(1);
            end else begin
              w_laps = r_laps;
            end
          end else if (w_idx == w_rev_idx) begin
            w_position = w_idx;
            w_dir      = 1'b1;
            w_step     = 1'b1;
            w_reversal = r_stepped && !r_dir;
            w_stepped  = 1'b1;
            if (r_position == {NB_POS{1'b0}}) begin
              w_laps = r_laps + NB_LAPS'(1);
            end else begin
              w_laps = r_laps;
            end
          end else begin
            w_state    = ST_ERROR;
            w_err_code = ERR_JUMP;
          end
        end
        ST_ERROR: begin
          w_state = ST_ERROR;
        end
        default: begin
          w_state    = ST_SEEK;
          w_position = {NB_POS{1'b0}};
          w_dir      = 1'b0;
          w_err_code = ERR_NONE;
          w_laps     = {NB_LAPS{1'b0}};
          w_stepped  = 1'b0;
        end
      endcase
    end else begin
      w_state = r_state;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_SEEK;
      r_position <= {NB_POS{1'b0}};
      r_dir      <= 1'b0;
      r_step     <= 1'b0;
      r_reversal <= 1'b0;
      r_locked   <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
      r_laps     <= {NB_LAPS{1'b0}};
      r_stepped  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_position <= w_position;
      r_dir      <= w_dir;
      r_step     <= w_step;
      r_reversal <= w_reversal;
      r_locked   <= (w_state == ST_TRACK);
      r_error    <= (w_state == ST_ERROR);
      r_err_code <= w_err_code;
      r_laps     <= w_laps;
      r_stepped  <= w_stepped;
    end
  end

  assign mon.o_position = r_position;
  assign mon.o_dir      = r_dir;
  assign mon.o_step     = r_step;
  assign mon.o_reversal = r_reversal;
  assign mon.o_locked   = r_locked;
  assign mon.o_error    = r_error;
  assign mon.o_err_code = r_err_code;
  assign mon.o_laps     = r_laps;

endmodule
